// File: rtl/mine_map_gen_ctrl.sv
// mine_map_gen_ctrl: owns the mine-map RAM while the board is generated. The
// sequencer clears every cell, draws candidate cells from a 16-bit LFSR, marks
// accepted candidates as mines, and increments the adjacency count of each
// in-bounds neighbour with a read-modify-write.
// Optional build macro: SAFE_FIRST_EN keeps safe_cell_i free of mines.
//
// Handshake: start_i is a one-cycle request that is accepted only in IDLE.
// busy_o is high from the next cycle until done_o. done_o is a one-cycle pulse.
// RAM reads have one cycle of latency: ram_rdata_i is valid in the cycle after
// an address is driven with ram_we_o=0. Writes take effect at the same edge.
module mine_map_gen_ctrl #(
  parameter int COLS      = 8,
  parameter int ROWS      = 8,
  parameter int AW        = 6,
  parameter int MAX_TRIES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [4:0]    mine_num_i,
  input  logic [15:0]   seed_i,
  input  logic [AW-1:0] safe_cell_i,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_we_o,
  output logic [4:0]    ram_wdata_o,
  input  logic [4:0]    ram_rdata_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [5:0]    mines_placed_o
);

  localparam int CELLS = COLS * ROWS;
  localparam int TW    = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [15:0] SEED_SUBST = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_CHECK,
    S_NB_RD,
    S_NB_WR,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d, lfsr_next;
  logic [AW-1:0] cand_q, cand_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [2:0]    k_q, k_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [5:0]    placed_q, placed_d;
  logic [4:0]    mine_num_q, mine_num_d;

  int            cand_col, cand_row, dc, dr, nb_col, nb_row;
  logic          nb_in;
  logic [AW-1:0] nb_addr;
  logic          safe_hit;
  logic          nb_step;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting towards the MSB.
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef SAFE_FIRST_EN
  assign safe_hit = (cand_q == safe_cell_i);
`else
  logic unused_safe_cell;
  assign safe_hit         = 1'b0;
  assign unused_safe_cell = ^safe_cell_i;
`endif

  // Neighbour k of the current candidate. Column and row bounds are checked
  // separately, so a neighbour never wraps onto the adjacent row.
  always_comb begin
    cand_col = int'(cand_q) % COLS;
    cand_row = int'(cand_q) / COLS;
    dc = 0;
    dr = 0;
    case (k_q)
      3'd0:    begin dc = -1; dr = -1; end
      3'd1:    begin dc =  0; dr = -1; end
      3'd2:    begin dc =  1; dr = -1; end
      3'd3:    begin dc = -1; dr =  0; end
      3'd4:    begin dc =  1; dr =  0; end
      3'd5:    begin dc = -1; dr =  1; end
      3'd6:    begin dc =  0; dr =  1; end
      default: begin dc =  1; dr =  1; end
    endcase
    nb_col  = cand_col + dc;
    nb_row  = cand_row + dr;
    nb_in   = (nb_col >= 0) && (nb_col < COLS) && (nb_row >= 0) && (nb_row < ROWS);
    nb_addr = AW'(nb_row * COLS + nb_col);
  end

  // Next-state, datapath updates and RAM/status outputs.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cand_d      = cand_q;
    idx_d       = idx_q;
    k_d         = k_q;
    tries_d     = tries_q;
    placed_d    = placed_q;
    mine_num_d  = mine_num_q;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    nb_step     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_CLEAR;
          placed_d   = '0;
          mine_num_d = mine_num_i;
          lfsr_d     = (seed_i == 16'h0000) ? SEED_SUBST : seed_i;
          idx_d      = '0;
          tries_d    = '0;
        end
      end
      S_CLEAR: begin
        busy_o      = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = idx_q;
        ram_wdata_o = '0;
        if (idx_q == AW'(CELLS - 1)) begin
          state_d = (mine_num_q == 5'd0) ? S_DONE : S_DRAW;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_DRAW: begin
        busy_o     = 1'b1;
        lfsr_d     = lfsr_next;
        cand_d     = lfsr_next[AW-1:0];
        ram_addr_o = lfsr_next[AW-1:0];
        tries_d    = tries_q + TW'(1);
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        busy_o     = 1'b1;
        ram_addr_o = cand_q;
        if ((int'(cand_q) >= CELLS) || ram_rdata_i[4] || safe_hit) begin
          state_d = (tries_q == TW'(MAX_TRIES)) ? S_DONE : S_DRAW;
        end else begin
          ram_we_o    = 1'b1;
          ram_wdata_o = ram_rdata_i | 5'h10;
          k_d         = 3'd0;
          state_d     = S_NB_RD;
        end
      end
      S_NB_RD: begin
        busy_o = 1'b1;
        if (nb_in) begin
          ram_addr_o = nb_addr;
          state_d    = S_NB_WR;
        end else begin
          nb_step = 1'b1;
        end
      end
      S_NB_WR: begin
        busy_o      = 1'b1;
        ram_addr_o  = nb_addr;
        ram_we_o    = 1'b1;
        ram_wdata_o = {ram_rdata_i[4], ram_rdata_i[3:0] + 4'd1};
        nb_step     = 1'b1;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Move to the next neighbour, or close out this mine after the eighth.
    if (nb_step) begin
      if (k_q == 3'd7) begin
        placed_d = placed_q + 6'd1;
        if ((placed_d == {1'b0, mine_num_q}) || (tries_q == TW'(MAX_TRIES))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAW;
        end
      end else begin
        k_d     = k_q + 3'd1;
        state_d = S_NB_RD;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= '0;
      cand_q     <= '0;
      idx_q      <= '0;
      k_q        <= '0;
      tries_q    <= '0;
      placed_q   <= '0;
      mine_num_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cand_q     <= cand_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      tries_q    <= tries_d;
      placed_q   <= placed_d;
      mine_num_q <= mine_num_d;
    end
  end

  assign mines_placed_o = placed_q;

endmodule

// File: tb/tb_mine_map_gen_ctrl.sv
// Bench for mine_map_gen_ctrl: two instances (MAX_TRIES 255 and 4), each with
// its own 64x5 synchronous RAM model, checked against a golden board model
// derived from the placement and adjacency rules.
module tb_mine_map_gen_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (MAX_TRIES=255) ----------------
  logic       start_a = 1'b0;
  logic [4:0] num_a = '0;
  logic [15:0] seed_a = '0;
  logic [5:0] safe_a = 6'd27;
  logic [5:0] addr_a;
  logic       we_a;
  logic [4:0] wdata_a;
  logic [4:0] rdata_a;
  logic       busy_a, done_a;
  logic [5:0] placed_a;
  logic [4:0] ram_a[64];
  logic       scr_a = 1'b0;

  mine_map_gen_ctrl #(.COLS(8), .ROWS(8), .AW(6), .MAX_TRIES(255)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .mine_num_i(num_a), .seed_i(seed_a),
    .safe_cell_i(safe_a), .ram_addr_o(addr_a), .ram_we_o(we_a), .ram_wdata_o(wdata_a),
    .ram_rdata_i(rdata_a), .busy_o(busy_a), .done_o(done_a), .mines_placed_o(placed_a)
  );

  // ---------------- DUT B (MAX_TRIES=4) ----------------
  logic       start_b = 1'b0;
  logic [4:0] num_b = '0;
  logic [15:0] seed_b = '0;
  logic [5:0] safe_b = 6'd27;
  logic [5:0] addr_b;
  logic       we_b;
  logic [4:0] wdata_b;
  logic [4:0] rdata_b;
  logic       busy_b, done_b;
  logic [5:0] placed_b;
  logic [4:0] ram_b[64];
  logic       scr_b = 1'b0;

  mine_map_gen_ctrl #(.COLS(8), .ROWS(8), .AW(6), .MAX_TRIES(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .mine_num_i(num_b), .seed_i(seed_b),
    .safe_cell_i(safe_b), .ram_addr_o(addr_b), .ram_we_o(we_b), .ram_wdata_o(wdata_b),
    .ram_rdata_i(rdata_b), .busy_o(busy_b), .done_o(done_b), .mines_placed_o(placed_b)
  );

  // Synchronous RAM models; scramble fills with junk so clearing is observable.
  always @(posedge clk) begin
    if (scr_a) for (int i = 0; i < 64; i++) ram_a[i] <= 5'($urandom);
    else if (we_a) ram_a[addr_a] <= wdata_a;
    rdata_a <= ram_a[addr_a];
  end
  always @(posedge clk) begin
    if (scr_b) for (int i = 0; i < 64; i++) ram_b[i] <= 5'($urandom);
    else if (we_b) ram_b[addr_b] <= wdata_b;
    rdata_b <= ram_b[addr_b];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];
  int exp_placed;

`ifdef SAFE_FIRST_EN
  localparam bit SAFE_ON = 1'b1;
`else
  localparam bit SAFE_ON = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Golden model: replay the draws, then count mine neighbours per cell.
  task automatic model_run(input logic [15:0] seed, input int num, input int max_tries,
                           input bit safe_en, input int safe_cell);
    logic [15:0] s;
    int tries, placed, cand, cnt;
    bit mine[64];
    for (int i = 0; i < 64; i++) mine[i] = 1'b0;
    s = (seed == 16'h0000) ? 16'hACE1 : seed;
    tries = 0;
    placed = 0;
    while (placed < num && tries < max_tries) begin
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      tries++;
      cand = int'(s[5:0]);
      if (!mine[cand] && !(safe_en && cand == safe_cell)) begin
        mine[cand] = 1'b1;
        placed++;
      end
    end
    exp_q.delete();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int ddr = -1; ddr <= 1; ddr++)
          for (int ddc = -1; ddc <= 1; ddc++)
            if (!(ddr == 0 && ddc == 0) && r + ddr >= 0 && r + ddr < 8 && c + ddc >= 0 && c + ddc < 8)
              cnt += int'(mine[(r + ddr) * 8 + c + ddc]);
        exp_q.push_back({mine[r * 8 + c], 4'(cnt)});
      end
    end
    exp_placed = placed;
  endtask

  task automatic check_board(input bit use_b, input string name);
    int bad, first;
    logic [4:0] got, exp, fgot, fexp;
    bad = 0; first = -1; fgot = '0; fexp = '0;
    for (int i = 0; i < 64; i++) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1F;
      got = use_b ? ram_b[i] : ram_a[i];
      if (got !== exp) begin
        if (bad == 0) begin first = i; fgot = got; fexp = exp; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s board: %0d cells differ, first cell %0d got %h expected %h",
               name, bad, first, fgot, fexp);
    end
  endtask

  task automatic run_a(input logic [15:0] seed, input logic [4:0] num, input string name);
    int cyc;
    scr_a = 1'b1; tick(); scr_a = 1'b0;
    seed_a = seed; num_a = num; start_a = 1'b1; tick(); start_a = 1'b0;
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 3000) begin tick(); cyc++; end
    check({name, "_done"}, done_a, 1);
    tick();
    check({name, "_done_one_cycle"}, {done_a, busy_a}, 0);
  endtask

  task automatic count_mines_a(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(ram_a[i][4]);
  endtask

  typedef struct {
    logic [15:0] seed;
    logic [4:0]  num;
    int          exp_placed;
    int          exp_mines;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n, cyc;
    bit any27;
    logic [15:0] sd;
    logic [4:0] nm;

    vecs[0] = '{16'h0001, 5'd0,  0,  0};
    vecs[1] = '{16'h0001, 5'd1,  1,  1};
    vecs[2] = '{16'hBEEF, 5'd31, 31, 31};
    vecs[3] = '{16'h0000, 5'd20, 20, 20};
    vecs[4] = '{16'h1234, 5'd8,  8,  8};

    // Reset state
    repeat (3) tick();
    check("reset_a_outputs", {addr_a, we_a, wdata_a, busy_a, done_a, placed_a}, 0);
    check("reset_b_outputs", {addr_b, we_b, wdata_b, busy_b, done_b, placed_b}, 0);
    rst_n = 1'b1;
    tick();

    // Empty board: 64 clearing writes, done right after, start at done ignored
    scr_a = 1'b1; tick(); scr_a = 1'b0;
    num_a = 5'd0; seed_a = 16'h0001; start_a = 1'b1; tick(); start_a = 1'b0;
    for (int i = 0; i < 64; i++) begin
      check($sformatf("clear_cycle%0d", i), {busy_a, we_a, addr_a, wdata_a}, {1'b1, 1'b1, 6'(i), 5'd0});
      tick();
    end
    check("t1_done_after_clear", {done_a, busy_a, we_a}, 3'b100);
    check("t1_placed", placed_a, 0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t1_done_pulse", done_a, 0);
    check("t1_start_at_done_ignored", busy_a, 0);
    tick();
    check("t1_still_idle", {busy_a, we_a}, 0);
    model_run(16'h0001, 0, 255, SAFE_ON, 27);
    check_board(1'b0, "t1");

    // Table of directed runs
    for (int v = 0; v < 5; v++) begin
      run_a(vecs[v].seed, vecs[v].num, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_placed", v), placed_a, vecs[v].exp_placed);
      count_mines_a(n);
      check($sformatf("vec%0d_mine_cells", v), n, vecs[v].exp_mines);
      model_run(vecs[v].seed, int'(vecs[v].num), 255, SAFE_ON, 27);
      check_board(1'b0, $sformatf("vec%0d", v));
    end

    // Tries cap on instance B
    scr_b = 1'b1; tick(); scr_b = 1'b0;
    seed_b = 16'hBEEF; num_b = 5'd31; start_b = 1'b1; tick(); start_b = 1'b0;
    cyc = 0;
    while (done_b !== 1'b1 && cyc < 3000) begin tick(); cyc++; end
    check("t4_done", done_b, 1);
    check("t4_done_in_budget", cyc <= 64 + 4 * 2 + 4 * 16, 1);
    check("t4_placed_le_4", placed_b <= 6'd4, 1);
    model_run(16'hBEEF, 31, 4, SAFE_ON, 27);
    check("t4_placed_model", placed_b, exp_placed);
    check_board(1'b1, "t4");
    tick();

    // Reset in the middle of the neighbour updates
    scr_a = 1'b1; tick(); scr_a = 1'b0;
    num_a = 5'd31; seed_a = 16'hBEEF; start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 3000) begin
      if (we_a && !wdata_a[4] && wdata_a != 5'd0) n++;
      if (n < 10) begin tick(); cyc++; end
    end
    check("t5_reached_nb_wr", n, 10);
    check("t5_placed_before_reset", placed_a != 6'd0, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t5_after_reset", {we_a, busy_a, done_a, placed_a}, 0);
    tick();
    run_a(16'hBEEF, 5'd31, "t5_rerun");
    check("t5_rerun_placed", placed_a, 31);
    model_run(16'hBEEF, 31, 255, SAFE_ON, 27);
    check_board(1'b0, "t5_rerun");

    // Random seeds and counts against the model
    for (int t = 0; t < 8; t++) begin
      sd = 16'($urandom);
      nm = 5'($urandom_range(0, 31));
      run_a(sd, nm, $sformatf("rand%0d", t));
      model_run(sd, int'(nm), 255, SAFE_ON, 27);
      check($sformatf("rand%0d_placed", t), placed_a, exp_placed);
      check_board(1'b0, $sformatf("rand%0d", t));
    end

    // Safe cell 27 over 20 seeds
    any27 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      sd = 16'($urandom);
      run_a(sd, 5'd31, $sformatf("safe%0d", t));
      model_run(sd, 31, 255, SAFE_ON, 27);
      check($sformatf("safe%0d_placed", t), placed_a, exp_placed);
      check_board(1'b0, $sformatf("safe%0d", t));
`ifdef SAFE_FIRST_EN
      check($sformatf("safe%0d_cell27_clear", t), ram_a[27][4], 0);
`else
      any27 = any27 | ram_a[27][4];
`endif
    end
`ifndef SAFE_FIRST_EN
    check("t6_some_mine_at_27", any27, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
